// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the management UART transmit arbiter.
// Holds the frame state encoding and the round-robin pick function.
package uart_arb_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // First set mask bit scanning upward from ptr+1, wrapping at n.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] mask,
    input logic [2:0] ptr,
    input int         n
  );
    logic [2:0] r;
    logic       hit;
    int         idx;
    r   = ptr;
    hit = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!hit && i <= n && mask[idx[2:0]]) begin
        r   = idx[2:0];
        hit = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bundle for the UART transmit arbiter.
// Sources drive the master side; the arbiter owns the slave side.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]                req_valid;
  logic [UART_DATA_BITS*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]                req_last;
  logic [NUM_REQ-1:0]                req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_tx_shifter.sv
// 8N1 serializer with its own baud counter.
// The divisor is latched at load so a frame never changes speed midway.
module uart_tx_shifter
  import uart_arb_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [7:0]           i_data,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_ser_tx,
  output logic                 o_tx_done,
  output logic                 o_busy
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;
  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic [1:0]           r_state;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [2:0]           r_idx;
  logic [7:0]           r_shift;
  logic                 r_tx;
  logic                 w_tick;

  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_div   <= i_div;
            r_cnt   <= i_div;
            r_shift <= i_data;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_cnt   <= r_div;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= r_div;
            if (r_idx == LAST_IDX) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ser_tx  = r_tx;
  assign o_tx_done = (r_state == S_STOP) && w_tick;
  assign o_busy    = (r_state != S_IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock feeding one shared UART line.
// A locked requester keeps the line until it sends a last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int DIV_WIDTH = 16,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 core_clk,
  input  logic                 core_rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] clk_div,
  uart_tx_arbiter_if.slave     bus,
  output logic                 ser_tx,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 tx_done
);

  logic               r_lock;
  logic [GW-1:0]      r_ptr;
  logic [GW-1:0]      r_grant;
  logic               w_sh_busy;
  logic               w_acc;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_ready;
  logic [7:0]         w_mask;
  logic [2:0]         w_ptr3;
  logic [GW-1:0]      w_win;
  logic [7:0]         w_byte;

  always_comb begin
    w_elig = bus.req_valid;
    if (r_lock) begin
      w_elig        = '0;
      w_elig[r_ptr] = bus.req_valid[r_ptr];
    end
    w_mask              = '0;
    w_mask[NUM_REQ-1:0] = w_elig;
    w_ptr3              = '0;
    w_ptr3[GW-1:0]      = r_ptr;
  end

  assign w_win  = GW'(rr_pick(w_mask, w_ptr3, NUM_REQ));
  assign w_acc  = ~core_rst & enable & ~w_sh_busy & (|w_elig);
  assign w_byte = bus.req_data[{w_win, 3'b000} +: 8];

  always_comb begin
    w_ready = '0;
    if (w_acc) w_ready[w_win] = 1'b1;
  end

  assign bus.req_ready = w_ready;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_lock  <= 1'b0;
      r_ptr   <= GW'(NUM_REQ - 1);
      r_grant <= '0;
    end else if (w_acc) begin
      r_lock  <= ~bus.req_last[w_win];
      r_ptr   <= w_win;
      r_grant <= w_win;
    end else if (!enable && !w_sh_busy) begin
      r_lock <= 1'b0;
    end
  end

  uart_tx_shifter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_shifter (
    .clk       (core_clk),
    .rst       (core_rst),
    .i_load    (w_acc),
    .i_data    (w_byte),
    .i_div     (clk_div),
    .o_ser_tx  (ser_tx),
    .o_tx_done (tx_done),
    .o_busy    (w_sh_busy)
  );

  assign busy     = w_sh_busy | r_lock;
  assign grant_id = r_grant;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single management UART transmit line `ser_tx` between NUM_REQ byte-stream requesters (management CPU, housekeeping, debug).
- Uses round-robin arbitration with packet lock, so one requester's multi-byte message is never interleaved with another's.
- Contains the baud-rate generator and the 8N1 serializer.
- Sits between the SoC's byte sources and the `ser_tx` pad, inside mgmt_core_wrapper.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- DIV_WIDTH, 16, width of the baud divisor.

Ports:
- core_clk  in  1  system clock.
- core_rst  in  1  asynchronous active-high reset.
- enable  in  1  arbitration enable; low = finish current frame, then idle.
- clk_div  in  DIV_WIDTH  bit period minus one, in core_clk cycles.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is last of message; releases lock.
- req_ready  out  NUM_REQ  one-hot, single-cycle accept strobe.
- ser_tx  out  1  serial output, idle high.
- busy  out  1  frame in progress or lock held.
- grant_id  out  clog2(NUM_REQ) (minimum 1)  requester owning current/last frame.
- tx_done  out  1  one-cycle pulse, last cycle of stop bit.

Behaviour:
- Reset is asynchronous and active-high on `core_rst`, with one clock, `core_clk`.
- Reset values:
  - ser_tx=1, req_ready=0, busy=0, tx_done=0, grant_id=0.
  - lock cleared; round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - state=IDLE.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If enable=1 and an eligible req_valid is set, pick the winner: the first set bit scanning upward from pointer+1, with wrap.
  - If lock is held, only the locked requester is eligible.
  - In the same cycle: req_ready[winner]=1, capture req_data, set grant_id=winner, pointer=winner.
  - Set lock = ~req_last[winner].
  - Load bit counter with clk_div, then go to START.
  - No eligible request: stay in IDLE with ser_tx=1.
- Timing:
  - Accept cycle T; ser_tx=0 from T+1.
  - clk_div is sampled at accept and held for the whole frame. A mid-frame change takes effect on the next frame.
  - Each bit lasts exactly clk_div+1 cycles; clk_div=0 gives 1 cycle per bit.
- START: drive 0 for one bit period, then go to DATA.
- DATA: 8 bits, LSB first, with a 3-bit index; after bit 7 go to STOP.
- STOP:
  - Drive 1 for one bit period.
  - tx_done=1 in its final cycle.
  - Return to IDLE.
- Earliest next accept is the cycle after STOP ends. Frame-to-frame start spacing is therefore 10*(clk_div+1)+1 cycles.
- Lock:
  - Held while the locked requester has valid=0: the line idles and other requesters wait.
  - Released on acceptance of a byte with req_last=1, or when enable=0 is seen in IDLE.
- enable falling mid-frame: the current frame completes unaltered. No new accept while enable=0; lock cleared.
- Simultaneous requests: round-robin order only. A requester whose req_valid and req_last are both high is served for one byte and then the pointer advances.
- req_valid dropping without acceptance is legal; the request is simply not considered.
- busy = (state!=IDLE) | lock.
- core_rst asserted mid-frame: ser_tx=1 immediately (asynchronous), all state and lock cleared. No partial-frame completion.

Decomposition:
- Package `uart_arb_pkg` holds:
  - state enum (IDLE, START, DATA, STOP);
  - UART_DATA_BITS=8;
  - a round-robin pick function (mask, pointer → index).
- Sub-module `uart_tx_shifter` holds the baud counter, bit index, shift register and ser_tx/tx_done. It has a load/data in interface and a busy out.
- The top level holds arbitration, lock, pointer and req_ready.

Test Plan:
- Reset, clk_div=3, req0 sends 8'h55 with last=1 → req_ready[0] pulse at T; ser_tx sequence 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles long, starting T+1; tx_done at T+40; tbuart decodes 'U'.
- req0 and req1 valid continuously with last=1, data 8'hA0/8'hB1 → accept order 0,1,0,1; grant_id alternates; start spacing 41 cycles at clk_div=3.
- req0 sends 3 bytes with last=0,0,1 while req1 is valid → req1 accepted only after the third req0 byte; busy stays high throughout; byte order on the line is 0,0,0,1.
- Locked req0 drops valid for 100 cycles while req1 is valid → ser_tx stays 1, no req_ready[1]; lock then released by deasserting enable in IDLE → req1 accepted after enable returns.
- enable falls on cycle 5 of a frame with clk_div=0 → frame completes in 10 bit cycles; no further req_ready while enable=0.
- core_rst pulsed during DATA bit 3 → ser_tx=1, busy=0 in the same cycle. After release, a fresh request from requester 0 is accepted first.
